// File: rtl/inst_mem_loader.sv
// Purpose: streams a program image byte-by-byte into instruction memory, NOP-pads the rest, then releases the CPU.
// Latency: one cycle from byte handshake (or pad step) to the registered memory write strobe.
// Backpressure: byte_ready is high only in LOAD; once the image ends or memory fills, the stream is stalled.
module inst_mem_loader #(
    parameter int                    WORD_LEN = 8,
    parameter int                    MEM_SIZE = 2048,
    parameter int                    INST_LEN = 32,
    parameter logic [INST_LEN-1:0]   NOP      = 32'hE0000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORD_LEN-1:0]  byte_in,
    input  logic                 byte_valid,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [INST_LEN-1:0]  wr_addr,
    output logic [WORD_LEN-1:0]  wr_data,
    output logic                 cpu_freeze,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [INST_LEN-1:0]  byte_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [INST_LEN-1:0] LAST_ADDR = INST_LEN'(MEM_SIZE - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [INST_LEN-1:0]    ptr;
    // Set once the top location has been written; PAD then spends one flush
    // cycle so the final write strobe is seen before done/cpu_freeze change.
    logic                   drain;
    logic                   hs;
    logic                   at_end;
    logic [WORD_LEN-1:0]    pad_byte;

    assign byte_ready = (state == LOAD);
    assign hs         = byte_valid & byte_ready;
    assign at_end     = (ptr == LAST_ADDR);
    assign cpu_freeze = (state != DONE);
    assign busy       = (state == LOAD) || (state == PAD);
    assign done       = (state == DONE);

    // Big-endian NOP byte for the current location within its word.
    always_comb begin
        pad_byte = '0;
        case (ptr[1:0])
            2'd0:    pad_byte = NOP[4*WORD_LEN-1 -: WORD_LEN];
            2'd1:    pad_byte = NOP[3*WORD_LEN-1 -: WORD_LEN];
            2'd2:    pad_byte = NOP[2*WORD_LEN-1 -: WORD_LEN];
            default: pad_byte = NOP[WORD_LEN-1   -: WORD_LEN];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: end of stream or full memory both leave LOAD via PAD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (hs && (byte_last || at_end)) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                if (drain) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: pointer, byte counter, sticky error and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            drain      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            error      <= 1'b0;
            byte_count <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ptr        <= '0;
                        drain      <= 1'b0;
                        error      <= 1'b0;
                        byte_count <= '0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= ptr;
                        wr_data    <= byte_in;
                        byte_count <= byte_count + 1'b1;
                        if (!at_end) begin
                            ptr <= ptr + 1'b1;
                        end
                        // Filling the top location means nothing is left to pad.
                        if (byte_last || at_end) begin
                            drain <= at_end;
                        end
                        // Last byte must close a word; running out of memory is an overflow.
                        if ((byte_last && (ptr[1:0] != 2'd3)) || (at_end && !byte_last)) begin
                            error <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (!drain) begin
                        wr_en   <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= pad_byte;
                        if (at_end) begin
                            drain <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    localparam int          MS   = 2048;
    localparam int          MSS  = 8;
    localparam logic [31:0] NOPV = 32'hE0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;

    logic        byte_ready, wr_en, cpu_freeze, busy, done, error;
    logic [31:0] wr_addr, byte_count;
    logic [7:0]  wr_data;
    logic        byte_ready_s, wr_en_s, cpu_freeze_s, busy_s, done_s, error_s;
    logic [31:0] wr_addr_s, byte_count_s;
    logic [7:0]  wr_data_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int d_big = -1;
    int d_sml = -1;

    logic [7:0] pb[$];
    int hsq[$];
    int wa[$], wd[$], wc[$];
    int wa_s[$], wd_s[$], wc_s[$];

    inst_mem_loader #(.MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_freeze(cpu_freeze),
        .busy(busy), .done(done), .error(error), .byte_count(byte_count)
    );

    inst_mem_loader #(.MEM_SIZE(MSS)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .cpu_freeze(cpu_freeze_s),
        .busy(busy_s), .done(done_s), .error(error_s), .byte_count(byte_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(int'(wr_addr)); wd.push_back(int'(wr_data)); wc.push_back(cyc);
        end
        if (wr_en_s === 1'b1) begin
            wa_s.push_back(int'(wr_addr_s)); wd_s.push_back(int'(wr_data_s)); wc_s.push_back(cyc);
        end
        if (done === 1'b1 && d_big < 0) d_big = cyc;
        if (done_s === 1'b1 && d_sml < 0) d_sml = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected image byte for a padded location: big-endian slice of NOP.
    function automatic int pad_byte(input int a);
        logic [31:0] v;
        v = NOPV >> (8 * (3 - (a % 4)));
        return int'(v[7:0]);
    endfunction

    task automatic fill(input int n);
        pb.delete();
        for (int i = 0; i < n; i++) pb.push_back(8'($urandom_range(0, 255)));
    endtask

    // Offer one byte; returns ok=1 if it was accepted within the bound.
    task automatic send(input logic [7:0] b, input bit last, input bit sml, output bit ok);
        byte_in = b; byte_valid = 1'b1; byte_last = last; ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if ((sml ? byte_ready_s : byte_ready) === 1'b1) begin
                @(posedge clk); #1;
                hsq.push_back(cyc);
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic pulse_start(input bit sml);
        if (sml) start_s = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_s = 1'b0;
    endtask

    // Full load into the large instance; gmode 0=no gaps, 1=valid 1,0,0 pattern, 2=random gaps.
    task automatic run_load(input int n, input int gmode, input bit pad_start);
        bit ok;
        int g, h, bad, first, ed, ec;
        wa.delete(); wd.delete(); wc.delete(); hsq.delete();
        pulse_start(1'b0);
        d_big = -1;
        chk("start_freeze", {31'd0, cpu_freeze}, 32'd1);
        chk("start_error", {31'd0, error}, 32'd0);
        chk("start_count", byte_count, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            send(pb[i], i == n - 1, 1'b0, ok);
            g = (gmode == 1) ? 2 : (gmode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
        chk("accepted", hsq.size(), n);
        h = (hsq.size() > 0) ? hsq[hsq.size() - 1] : 0;
        if (pad_start) begin
            repeat (5) @(posedge clk);
            #1;
            pulse_start(1'b0);
        end
        for (int t = 0; t < 5000 && d_big < 0; t++) @(negedge clk);
        chk("write_count", wa.size(), MS);
        bad = 0; first = -1;
        for (int k = 0; k < wa.size(); k++) begin
            ed = (k < n) ? int'(pb[k]) : pad_byte(k);
            ec = (k < n) ? ((k < hsq.size()) ? hsq[k] : -1) : h + k - n + 1;
            if (wa[k] != k || wd[k] != ed || wc[k] != ec) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (bad != 0) $display("first bad write index %0d", first);
        chk("image", bad, 0);
        chk("done_cycle", d_big, h + MS - n + 1);
        chk("done", {31'd0, done}, 32'd1);
        chk("freeze_released", {31'd0, cpu_freeze}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("error_end", {31'd0, error}, {31'd0, (n % 4) != 0});
        chk("byte_count", byte_count, n);
    endtask

    initial begin
        bit ok;
        int acc, bad;

        // Reset state.
        #12;
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_freeze", {31'd0, cpu_freeze}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_count", byte_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single instruction.
        pb.delete();
        pb.push_back(8'hE3); pb.push_back(8'hA0); pb.push_back(8'h00); pb.push_back(8'h14);
        run_load(4, 0, 1'b0);

        // 8-byte stream with valid gaps.
        fill(8);
        run_load(8, 1, 1'b0);

        // Misaligned last, plus a start pulse during PAD.
        fill(6);
        run_load(6, 0, 1'b1);

        // Random loads (each reload starts from DONE).
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 24));
            fill(n);
            run_load(n, 2, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-load.
        fill(3);
        hsq.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) send(pb[i], 1'b0, 1'b0, ok);
        chk("midload_wr_en_before", {31'd0, wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_ready", {31'd0, byte_ready}, 32'd0);
        chk("arst_freeze", {31'd0, cpu_freeze}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        fill(int'($urandom_range(1, 16)));
        run_load(pb.size(), 0, 1'b0);

        // Overflow on the small instance: 9 bytes, no last.
        fill(9);
        hsq.delete(); wa_s.delete(); wd_s.delete(); wc_s.delete();
        pulse_start(1'b1);
        d_sml = -1;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            send(pb[i], 1'b0, 1'b1, ok);
            if (ok) acc++;
        end
        chk("ovf_accepted", acc, 8);
        chk("ovf_ready", {31'd0, byte_ready_s}, 32'd0);
        chk("ovf_writes", wa_s.size(), MSS);
        bad = 0;
        for (int k = 0; k < wa_s.size(); k++)
            if (wa_s[k] != k || k >= 8 || wd_s[k] != int'(pb[k]) || wc_s[k] != hsq[k]) bad++;
        chk("ovf_image", bad, 0);
        chk("ovf_error", {31'd0, error_s}, 32'd1);
        chk("ovf_done", {31'd0, done_s}, 32'd1);
        chk("ovf_done_cycle", d_sml, (hsq.size() == 8) ? hsq[7] + 1 : -2);
        chk("ovf_count", byte_count_s, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the byte-addressed instruction memory.
- Accepts a program as a byte stream over a valid/ready handshake and issues one byte write per cycle into the memory's write port, big-endian: first byte of an instruction goes to the lowest address, so a word read at address a is {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Fills all unused locations with NOP and holds the CPU frozen until the image is complete.

Parameters:
- WORD_LEN, 8, memory word width in bits (one byte per location).
- MEM_SIZE, 2048, number of memory locations; a multiple of 4.
- INST_LEN, 32, instruction and address width.
- NOP, 32'hE0000000, fill instruction written to unused words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE or DONE.
- byte_in  in  WORD_LEN  program byte.
- byte_valid  in  1  byte_in valid.
- byte_last  in  1  qualifies the final program byte; sampled with byte_valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  memory byte write strobe (registered).
- wr_addr  out  INST_LEN  memory byte address (registered).
- wr_data  out  WORD_LEN  memory byte data (registered).
- cpu_freeze  out  1  holds the pipeline/PC while high.
- busy  out  1  high in LOAD or PAD.
- done  out  1  high in DONE.
- error  out  1  sticky: misaligned last or overflow in the current load.
- byte_count  out  INST_LEN  bytes accepted in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_freeze=1, busy=0, done=0, error=0, byte_count=0.
  - Internal address pointer = 0.
- States:
  - IDLE: cpu_freeze=1. start -> LOAD; pointer=0, byte_count=0, error=0.
  - LOAD: byte_ready=1 (combinational from state). Handshake = byte_valid & byte_ready. On handshake:
    - Cycle N+1: wr_en=1, wr_addr=pointer, wr_data=byte_in. The pointer and byte_count then increment.
    - byte_last=1 with pointer[1:0]==3: go to PAD.
    - byte_last=1 with pointer[1:0]!=3: set error=1 and go to PAD.
    - pointer==MEM_SIZE-1 without last: set error=1 (overflow) and go to DONE; no padding.
    - No handshake: wr_en=0 next cycle; state holds indefinitely.
  - PAD: byte_ready=0. Writes one byte per cycle at the pointer, then increments it.
    - wr_data = NOP byte selected by pointer[1:0]: 0 -> NOP[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
    - After writing MEM_SIZE-1, go to DONE.
    - On a misaligned last, the remainder of the partial word is padded using the same rule.
  - DONE: cpu_freeze=0, done=1, byte_ready=0. start -> LOAD (cpu_freeze=1 from the next cycle, error cleared).
- start while in LOAD or PAD is ignored.
- wr_en deasserts the cycle after the last write. done and cpu_freeze=0 take effect the cycle after the final write strobe is issued, so the CPU never fetches a half-written image.
- The pointer never exceeds MEM_SIZE-1; there is no wrap-around.
- byte_count saturates implicitly at MEM_SIZE.
- Reset mid-LOAD or mid-PAD aborts immediately. Already-written memory contents are undefined to the CPU, and cpu_freeze stays 1 until a new load completes.

Test Plan:
- Single instruction: after reset, start, send E3,A0,00,14 with last on 14.
  - Writes at addr 0..3 with those bytes, then pad 4..2047 (addr 4=E0, addr 5..7=00).
  - done=1 and cpu_freeze=0 exactly 2044 cycles after the last handshake plus one.
  - error=0, byte_count=4.
- Backpressure/gaps: the same 8-byte stream with byte_valid toggling 1,0,0,1...
  - wr_en only on cycles following a handshake.
  - Addresses strictly consecutive 0..7, no duplicate or skipped writes.
- Misaligned last: 6 bytes with last on the 6th.
  - error=1.
  - addr 6=NOP[15:8]=00, addr 7=00, addr 8=E0, then normal padding to DONE.
- Overflow (MEM_SIZE=8): 9 bytes offered without last.
  - 8 accepted; byte_ready=0 from the 9th onward.
  - error=1, done=1, no PAD writes.
- Reset mid-load: assert rst_n=0 asynchronously after 3 accepted bytes.
  - wr_en=0, byte_ready=0, cpu_freeze=1, busy=0 without waiting for a clock edge.
  - A fresh start then reloads from addr 0.
- Reload from DONE: a start pulse raises cpu_freeze on the next cycle and clears error and byte_count. A start during PAD is ignored: the pad sequence is unchanged.
